// File: rtl/ftdi_fifo_emu_if.sv
// Master-side bus of the FT245-style synchronous FIFO, seen from the FPGA
// master and from the emulated FT2232H chip.
interface ftdi_fifo_emu_if;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rxf_n;
    logic       oe_n;
    logic       rd_n;
    logic       txe_n;
    logic       wr_n;

    modport master (
        input  data_out, data_oe, rxf_n, txe_n,
        output data_in, oe_n, rd_n, wr_n
    );

    modport slave (
        input  data_in, oe_n, rd_n, wr_n,
        output data_out, data_oe, rxf_n, txe_n
    );
endinterface

// File: rtl/ftdi_fifo_emu.sv
// FT2232H chip-side emulator of the synchronous FIFO interface: an RFIFO
// feeds master reads from the host stream, a WFIFO forwards master writes.
module ftdi_fifo_emu #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    ftdi_fifo_emu_if.slave bus,
    input  logic [7:0]     host_tx_tdata,
    input  logic           host_tx_tvalid,
    output logic           host_tx_tready,
    output logic [7:0]     host_rx_tdata,
    output logic           host_rx_tvalid,
    input  logic           host_rx_tready,
    output logic           rd_err,
    output logic           wr_err
);
    localparam int              CNT_W    = AW + 1;
    localparam logic [AW:0]     FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [7:0]    rmem [DEPTH];
    logic [7:0]    wmem [DEPTH];
    logic [AW-1:0] rptr_wr, rptr_rd, wptr_wr, wptr_rd;
    logic [AW:0]   rcount, rcount_next, wcount, wcount_next;
    logic          r_push, r_pop, w_push, w_pop;

    // Strobes qualify against the registered flags, so a master that obeys
    // rxf_n/txe_n can never under- or overflow either FIFO.
    assign r_push = host_tx_tvalid & host_tx_tready;
    assign r_pop  = ~bus.rd_n & ~bus.rxf_n;
    assign w_push = ~bus.wr_n & ~bus.txe_n;
    assign w_pop  = host_rx_tvalid & host_rx_tready;

    assign bus.data_out  = rmem[rptr_rd];
    assign host_rx_tdata = wmem[wptr_rd];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rcount_next = rcount;
        wcount_next = wcount;
        if (r_push && !r_pop)      rcount_next = rcount + CNT_ONE;
        else if (!r_push && r_pop) rcount_next = rcount - CNT_ONE;
        if (w_push && !w_pop)      wcount_next = wcount + CNT_ONE;
        else if (!w_push && w_pop) wcount_next = wcount - CNT_ONE;
    end

    // NOTE: the byte storage has no reset; clearing pointers and counts is enough to make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (r_push && !rst) rmem[rptr_wr] <= host_tx_tdata;
        if (w_push && !rst) wmem[wptr_wr] <= bus.data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_wr        <= '0;
            rptr_rd        <= '0;
            wptr_wr        <= '0;
            wptr_rd        <= '0;
            rcount         <= '0;
            wcount         <= '0;
            bus.rxf_n      <= 1'b1;
            bus.txe_n      <= 1'b1;
            bus.data_oe    <= 1'b0;
            host_tx_tready <= 1'b0;
            host_rx_tvalid <= 1'b0;
            rd_err         <= 1'b0;
            wr_err         <= 1'b0;
        end else begin
            if (r_push) rptr_wr <= rptr_wr + PTR_ONE;
            if (r_pop)  rptr_rd <= rptr_rd + PTR_ONE;
            if (w_push) wptr_wr <= wptr_wr + PTR_ONE;
            if (w_pop)  wptr_rd <= wptr_rd + PTR_ONE;
            rcount         <= rcount_next;
            wcount         <= wcount_next;
            bus.rxf_n      <= (rcount_next == '0);
            host_tx_tready <= (rcount_next != FULL_CNT);
            bus.txe_n      <= (wcount_next == FULL_CNT);
            host_rx_tvalid <= (wcount_next != '0);
            // One cycle of output-enable latency mirrors the chip's bus turnaround.
            bus.data_oe    <= ~bus.oe_n;
            if (~bus.rd_n & bus.rxf_n) rd_err <= 1'b1;
            if (~bus.wr_n & bus.txe_n) wr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ftdi_fifo_emu.sv
// Directed bench for ftdi_fifo_emu: FIFO transfers, full/empty boundaries,
// error flags, reset mid-transfer and a randomised loopback through a master.
module tb_ftdi_fifo_emu;
    localparam int N = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] host_tx_tdata;
    logic       host_tx_tvalid;
    logic       host_tx_tready;
    logic [7:0] host_rx_tdata;
    logic       host_rx_tvalid;
    logic       host_rx_tready;
    logic       rd_err;
    logic       wr_err;

    int passed     = 0;
    int total      = 0;
    int contention = 0;

    ftdi_fifo_emu_if bus ();

    ftdi_fifo_emu #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .host_tx_tdata  (host_tx_tdata),
        .host_tx_tvalid (host_tx_tvalid),
        .host_tx_tready (host_tx_tready),
        .host_rx_tdata  (host_rx_tdata),
        .host_rx_tvalid (host_rx_tvalid),
        .host_rx_tready (host_rx_tready),
        .rd_err         (rd_err),
        .wr_err         (wr_err)
    );

    always #5 clk = ~clk;

    // Bus contention: the emulator driving the bus while the master writes.
    always @(posedge clk) begin
        if (bus.data_oe === 1'b1 && bus.wr_n === 1'b0) contention <= contention + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] src [N];
    logic [7:0] mq [$];
    int  tx_idx, rx_idx, mism, cyc;
    logic tx_fire, rx_fire;

    initial begin
        bus.data_in    = 8'h00;
        bus.oe_n       = 1'b1;
        bus.rd_n       = 1'b1;
        bus.wr_n       = 1'b1;
        host_tx_tdata  = 8'h00;
        host_tx_tvalid = 1'b0;
        host_rx_tready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_rxf_n", 32'(bus.rxf_n), 1);
        check("rst_txe_n", 32'(bus.txe_n), 1);
        check("rst_data_oe", 32'(bus.data_oe), 0);
        check("rst_tx_tready", 32'(host_tx_tready), 0);
        check("rst_rx_tvalid", 32'(host_rx_tvalid), 0);
        check("rst_rd_err", 32'(rd_err), 0);
        check("rst_wr_err", 32'(wr_err), 0);
        rst = 1'b0;
        step();
        check("post_rst_txe_n", 32'(bus.txe_n), 0);
        check("post_rst_tready", 32'(host_tx_tready), 1);

        // 1: fill RFIFO with 0x00..0x0F, master reads them back
        for (int i = 0; i < 16; i++) begin
            host_tx_tvalid = 1'b1;
            host_tx_tdata  = 8'(i);
            step();
        end
        host_tx_tvalid = 1'b0;
        check("t1_full_tready", 32'(host_tx_tready), 0);
        check("t1_rxf_n_low", 32'(bus.rxf_n), 0);
        bus.oe_n = 1'b0;
        step();
        check("t1_data_oe", 32'(bus.data_oe), 1);
        for (int i = 0; i < 16; i++) begin
            check("t1_rxf_n_avail", 32'(bus.rxf_n), 0);
            check("t1_data", 32'(bus.data_out), i);
            bus.rd_n = 1'b0;
            step();
        end
        bus.rd_n = 1'b1;
        check("t1_rxf_n_empty", 32'(bus.rxf_n), 1);
        check("t1_rd_err", 32'(rd_err), 0);
        check("t1_tready_back", 32'(host_tx_tready), 1);
        bus.oe_n = 1'b1;
        step();
        check("t1_data_oe_off", 32'(bus.data_oe), 0);

        // 2: master writes 0xA0..0xAF with the host stalled
        for (int i = 0; i < 16; i++) begin
            check("t2_txe_n_avail", 32'(bus.txe_n), 0);
            bus.wr_n    = 1'b0;
            bus.data_in = 8'(8'hA0 + i);
            step();
        end
        check("t2_txe_n_full", 32'(bus.txe_n), 1);
        check("t2_rx_tvalid", 32'(host_rx_tvalid), 1);
        check("t2_wr_err_clean", 32'(wr_err), 0);
        bus.data_in = 8'hEE;
        step();
        bus.wr_n = 1'b1;
        check("t2_wr_err_set", 32'(wr_err), 1);
        check("t2_txe_n_still", 32'(bus.txe_n), 1);
        host_rx_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_rx_tvalid_d", 32'(host_rx_tvalid), 1);
            check("t2_rx_data", 32'(host_rx_tdata), 8'hA0 + i);
            step();
        end
        host_rx_tready = 1'b0;
        check("t2_rx_empty", 32'(host_rx_tvalid), 0);
        check("t2_txe_n_free", 32'(bus.txe_n), 0);

        // 3: RFIFO held at 8 entries with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            host_tx_tvalid = 1'b1;
            host_tx_tdata  = 8'(8'h10 + i);
            step();
        end
        host_tx_tvalid = 1'b0;
        bus.oe_n = 1'b0;
        step();
        for (int k = 0; k < 50; k++) begin
            check("t3_rxf_n", 32'(bus.rxf_n), 0);
            check("t3_tready", 32'(host_tx_tready), 1);
            check("t3_data", 32'(bus.data_out), 8'(8'h10 + k));
            host_tx_tvalid = 1'b1;
            host_tx_tdata  = 8'(8'h18 + k);
            bus.rd_n       = 1'b0;
            step();
        end
        host_tx_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", 32'(bus.data_out), 8'h42 + i);
            step();
        end
        bus.rd_n = 1'b1;
        check("t3_count8_empty", 32'(bus.rxf_n), 1);
        bus.oe_n = 1'b1;
        step();

        // 4: read strobe on an empty RFIFO, then reset pulse
        bus.rd_n = 1'b0;
        step();
        bus.rd_n = 1'b1;
        check("t4_rd_err", 32'(rd_err), 1);
        check("t4_rxf_n", 32'(bus.rxf_n), 1);
        host_tx_tvalid = 1'b1;
        host_tx_tdata  = 8'h5A;
        step();
        host_tx_tvalid = 1'b0;
        check("t4_ptr_kept", 32'(bus.data_out), 8'h5A);
        check("t4_one_entry", 32'(bus.rxf_n), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rd_err_clr", 32'(rd_err), 0);
        check("t4_wr_err_clr", 32'(wr_err), 0);
        check("t4_rxf_n_rst", 32'(bus.rxf_n), 1);
        check("t4_txe_n_rst", 32'(bus.txe_n), 1);
        step();

        // 5: reset with five bytes queued each way and strobes active
        for (int i = 0; i < 5; i++) begin
            host_tx_tvalid = 1'b1;
            host_tx_tdata  = 8'(8'h60 + i);
            bus.wr_n       = 1'b0;
            bus.data_in    = 8'(8'hB0 + i);
            step();
        end
        host_tx_tvalid = 1'b0;
        bus.wr_n = 1'b1;
        check("t5_rq_filled", 32'(bus.rxf_n), 0);
        check("t5_wq_head", 32'(host_rx_tdata), 8'hB0);
        rst            = 1'b1;
        bus.rd_n       = 1'b0;
        bus.wr_n       = 1'b0;
        host_tx_tvalid = 1'b1;
        host_rx_tready = 1'b1;
        step();
        rst            = 1'b0;
        bus.rd_n       = 1'b1;
        bus.wr_n       = 1'b1;
        host_tx_tvalid = 1'b0;
        host_rx_tready = 1'b0;
        check("t5_rxf_n_rst", 32'(bus.rxf_n), 1);
        check("t5_tvalid_rst", 32'(host_rx_tvalid), 0);
        check("t5_err_rst", 32'({rd_err, wr_err}), 0);
        step();
        check("t5_txe_n_ready", 32'(bus.txe_n), 0);
        check("t5_tready_ready", 32'(host_tx_tready), 1);
        check("t5_rq_empty", 32'(bus.rxf_n), 1);
        check("t5_wq_empty", 32'(host_rx_tvalid), 0);
        host_tx_tvalid = 1'b1;
        host_tx_tdata  = 8'h77;
        bus.wr_n       = 1'b0;
        bus.data_in    = 8'hC3;
        step();
        host_tx_tvalid = 1'b0;
        bus.wr_n       = 1'b1;
        check("t5_rq_fresh", 32'(bus.data_out), 8'h77);
        check("t5_wq_fresh", 32'(host_rx_tdata), 8'hC3);
        bus.rd_n       = 1'b0;
        host_rx_tready = 1'b1;
        step();
        bus.rd_n       = 1'b1;
        host_rx_tready = 1'b0;
        check("t5_drained", 32'({bus.rxf_n, host_rx_tvalid}), 2);

        // 6: randomised loopback through a master that obeys the flags
        for (int i = 0; i < N; i++) src[i] = 8'($urandom);
        tx_idx = 0;
        rx_idx = 0;
        mism   = 0;
        cyc    = 0;
        while (rx_idx < N && cyc < 40000) begin
            if (!host_tx_tvalid && tx_idx < N) begin
                host_tx_tvalid = 1'($urandom_range(0, 1));
                host_tx_tdata  = src[tx_idx];
            end
            host_rx_tready = 1'($urandom_range(0, 1));
            bus.rd_n = 1'b1;
            bus.wr_n = 1'b1;
            if (bus.oe_n == 1'b0) begin
                if (bus.rxf_n == 1'b0 && mq.size() < 8 && $urandom_range(0, 7) != 0) begin
                    if (bus.data_oe) begin
                        bus.rd_n = 1'b0;
                        mq.push_back(bus.data_out);
                    end
                end else begin
                    bus.oe_n = 1'b1;
                end
            end else if (mq.size() > 0 && !bus.txe_n && !bus.data_oe && $urandom_range(0, 3) != 0) begin
                bus.wr_n    = 1'b0;
                bus.data_in = mq.pop_front();
            end else if (!bus.rxf_n && $urandom_range(0, 1) == 1) begin
                bus.oe_n = 1'b0;
            end
            tx_fire = host_tx_tvalid && host_tx_tready;
            rx_fire = host_rx_tvalid && host_rx_tready;
            if (rx_fire && host_rx_tdata !== src[rx_idx]) mism++;
            step();
            cyc++;
            if (tx_fire) begin
                tx_idx++;
                host_tx_tvalid = 1'b0;
            end
            if (rx_fire) rx_idx++;
        end
        host_tx_tvalid = 1'b0;
        host_rx_tready = 1'b0;
        bus.oe_n       = 1'b1;
        bus.rd_n       = 1'b1;
        bus.wr_n       = 1'b1;
        step();
        check("t6_rx_count", rx_idx, N);
        check("t6_tx_count", tx_idx, N);
        check("t6_data", mism, 0);
        check("t6_rd_err", 32'(rd_err), 0);
        check("t6_wr_err", 32'(wr_err), 0);
        check("t6_contention", contention, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ftdi_fifo_emu.md
Name: ftdi_fifo_emu

Overview:
- Synthesizable emulator of the FT2232H chip side of the FT245-style synchronous FIFO interface; it is the responder to the FPGA-side FIFO interface master.
- Drives rxf_n/txe_n and the data bus. Answers rd_n/oe_n/wr_n exactly as the chip does, clocked by the same clk the master samples.
- Host-side AXI-stream ports stand in for the USB host: bytes pushed on host_tx reach the master through reads, and bytes written by the master appear on host_rx.
- Used in loopback benches and on-board self-test in place of the behavioural chip model.

Parameters:
- DEPTH, 16: entries in each internal FIFO; power of 2, at least 4.
- AW, $clog2(DEPTH): FIFO address width; derived, do not override.

Ports:
- clk  input  1: single clock; also the emulated chip clkout.
- rst  input  1: synchronous, active-high reset.
- data_in  input  8: bus value driven by the master (valid when wr_n low).
- data_out  output  8: bus value driven by the emulator.
- data_oe  output  1: enable for the data_out tristate.
- rxf_n  output  1: low when read data is available to the master.
- oe_n  input  1: master output-enable request; low asks the emulator to drive the bus.
- rd_n  input  1: master read strobe, active low.
- txe_n  output  1: low when the master may write.
- wr_n  input  1: master write strobe, active low.
- host_tx_tdata  input  8: host-to-FPGA byte.
- host_tx_tvalid  input  1: host-to-FPGA byte valid.
- host_tx_tready  output  1: emulator can accept a host-to-FPGA byte.
- host_rx_tdata  output  8: FPGA-to-host byte.
- host_rx_tvalid  output  1: FPGA-to-host byte valid.
- host_rx_tready  input  1: host accepts the FPGA-to-host byte.
- rd_err  output  1: sticky; a read was attempted while unavailable.
- wr_err  output  1: sticky; a write was attempted while unavailable.

Behaviour:
- Reset values (all synchronous, applied the cycle rst is high):
  - rxf_n=1, txe_n=1, data_oe=0, host_tx_tready=0, host_rx_tvalid=0.
  - rd_err=0, wr_err=0, both FIFO counts=0.
  - Pointers clear. FIFO contents are not reset.
- Two FIFOs, each with AW-bit read/write pointers that wrap modulo DEPTH and an (AW+1)-bit count from 0 to DEPTH:
  - RFIFO carries host to master.
  - WFIFO carries master to host.
- RFIFO push occurs when host_tx_tvalid & host_tx_tready.
- RFIFO pop occurs at the edge where rd_n==0 & rxf_n==0.
  - Both flags are sampled as registered values.
  - A simultaneous push and pop leaves the count unchanged.
- WFIFO push occurs at the edge where wr_n==0 & txe_n==0.
  - data_in is captured on that same edge.
- WFIFO pop occurs when host_rx_tvalid & host_rx_tready.
- All status outputs are registered from the next-state count, so each reflects the cycle's push/pop one cycle later:
  - rxf_n <= (rcount_next==0).
  - host_tx_tready <= (rcount_next!=DEPTH).
  - txe_n <= (wcount_next==DEPTH).
  - host_rx_tvalid <= (wcount_next!=0).
- Consequence: a master that pops only when rxf_n is low never underflows, and a master that writes only when txe_n is low never overflows. This holds even with back-to-back strobes.
- data_out is RFIFO head data, first-word fall-through, combinational from the read pointer.
  - After a pop, the next byte is on data_out in the following cycle.
- data_oe <= ~oe_n, giving 1 cycle of latency; this mirrors the chip's bus turnaround.
  - data_oe must never be high in a cycle where the master drives wr_n low; otherwise the bus contends.
  - oe_n low together with wr_n low is a master protocol error. It is not flagged here, but the bench asserts against it.
- host_rx_tdata is WFIFO head data, first-word fall-through.
- rd_err sets when rd_n==0 & rxf_n==1 at an edge. wr_err sets when wr_n==0 & txe_n==1 at an edge.
  - Both are sticky until rst.
  - FIFO state is unchanged by the offending strobe.
- Reset asserted mid-transfer:
  - All in-flight bytes are discarded.
  - Strobes present during the rst cycle are ignored.
  - The first legal access is the second cycle after rst falls, when the status flags have updated.
- Full and empty boundaries:
  - Filling to DEPTH drives host_tx_tready low.
  - At empty, data_out holds its last value but is don't-care.

Test Plan:
1. Push 0x00..0x0F on host_tx, then have the master read with oe_n low followed by rd_n low:
   - Master receives 0x00..0x0F in order.
   - rxf_n returns to 1 one cycle after the 16th pop.
   - rd_err stays 0.
2. Master writes 0xA0..0xAF back-to-back with host_rx_tready=0:
   - txe_n goes high one cycle after the 16th write.
   - A 17th strobe with wr_n low sets wr_err=1 and the count stays 16.
   - Releasing tready yields 0xA0..0xAF on host_rx.
3. Hold the RFIFO at count 8 with host push and master pop in the same cycles for 50 cycles:
   - Count stays 8 throughout.
   - rxf_n and host_tx_tready stay asserted.
   - The delivered sequence is continuous.
4. Strobe rd_n low while RFIFO is empty:
   - rd_err=1 the next cycle and the pointers are unchanged.
   - Pulse rst: rd_err=0, rxf_n=1, txe_n=1.
5. Assert rst while 5 bytes are queued in each FIFO:
   - Both FIFOs read empty after reset.
   - txe_n=0 and host_tx_tready=1 in the second cycle after rst falls.
6. Loopback with the FPGA-side master plus a random stream of 1000 bytes and random tvalid/tready:
   - host_rx sequence equals the host_tx sequence.
   - No error flags are set.
   - data_oe is never 1 in a cycle with wr_n low.
